// File: rtl/csr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : csr_pkg                                                    |
// | Description : Shared CSR access definitions: funct3 encodings, the       |
// |               read-modify-write sequencer states, requester identities   |
// |               and the read-only address prefix.                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package csr_pkg;

  // funct3 encodings of the Zicsr instructions; 000 and 100 are unused.
  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  // Top two address bits equal to this value mark a read-only CSR.
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } csr_owner_e;

endpackage
`default_nettype wire

// File: rtl/csr_access_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : csr_access_arbiter_if                                      |
// | Description : One requester's CSR request/response channel.             |
// |   req_valid  : request present             (requester -> arbiter)       |
// |   req_ready  : request accepted this cycle (arbiter -> requester)       |
// |   op         : funct3 of the CSR instruction                             |
// |   addr       : CSR address                                               |
// |   wdata      : rs1 value or zero-extended uimm                           |
// |   resp_valid : one-cycle response pulse                                  |
// |   rdata      : old CSR value, held until the next response              |
// |   resp_err   : illegal op or write to a read-only CSR                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface csr_access_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] rdata;
  logic              resp_err;

  modport master (
    output req_valid, op, addr, wdata,
    input  req_ready, resp_valid, rdata, resp_err
  );

  modport slave (
    input  req_valid, op, addr, wdata,
    output req_ready, resp_valid, rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/csr_rmw_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : csr_rmw_alu                                                |
// | Description : Combinational CSR read-modify-write datapath. Computes the |
// |               new value, the write enable after RISC-V write-suppression |
// |               rules, and the error flag.                                 |
// |   op       in  funct3                                                    |
// |   old      in  current CSR value                                         |
// |   wdata    in  rs1 value / uimm                                          |
// |   addr     in  CSR address (only the read-only prefix is examined)       |
// |   new_data out value to write back                                       |
// |   wen      out write back new_data                                       |
// |   err      out illegal op, or a write attempted to a read-only CSR       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] old,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] new_data,
  output logic              wen,
  output logic              err
);

  logic writes;
  logic illegal;
  logic read_only;
  logic unused_addr_bits;

  assign read_only        = (addr[ADDR_W-1 -: 2] == CSR_RO_PREFIX);
  assign unused_addr_bits = ^addr[ADDR_W-3:0];

  always_comb begin
    new_data = old;
    writes   = 1'b0;
    illegal  = 1'b0;
    case (op)
      CSRRW, CSRRWI: begin
        new_data = wdata;
        writes   = 1'b1;
      end
      CSRRS, CSRRSI: begin
        new_data = old | wdata;
        writes   = |wdata;   // set with zero mask is a pure read
      end
      CSRRC, CSRRCI: begin
        new_data = old & ~wdata;
        writes   = |wdata;   // clear with zero mask is a pure read
      end
      default: illegal = 1'b1;
    endcase
  end

  // A read-only CSR may be read freely; only an attempted write faults.
  assign wen = writes & ~read_only;
  assign err = illegal | (writes & read_only);

endmodule
`default_nettype wire

// File: rtl/csr_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : csr_access_arbiter                                         |
// | Description : Serialises core and debug accesses to the shared CSR file  |
// |               (one read port, one write port). Each accepted op runs a   |
// |               fixed IDLE->READ->WRITE->RESP sequence; ties between the   |
// |               two requesters are broken round-robin.                     |
// |   clk          in  clock                                                 |
// |   rst          in  asynchronous active-high reset                        |
// |   core, dbg    slave request/response channels                           |
// |   csr_addr     out file address for both read and write                  |
// |   csr_rd_data  in  combinational file read data                          |
// |   csr_we       out file write enable                                     |
// |   csr_wr_data  out file write data                                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module csr_access_arbiter
  import csr_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  csr_access_arbiter_if.slave core,
  csr_access_arbiter_if.slave dbg,
  output logic [ADDR_W-1:0]   csr_addr,
  input  logic [DATA_W-1:0]   csr_rd_data,
  output logic                csr_we,
  output logic [DATA_W-1:0]   csr_wr_data
);

  csr_state_e        state_q;
  csr_owner_e        last_grant_q;   // also identifies the in-flight owner
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              we_q;
  logic              err_q;
  logic              core_resp_valid_q, dbg_resp_valid_q;
  logic [DATA_W-1:0] core_rdata_q, dbg_rdata_q;
  logic              core_err_q, dbg_err_q;

  logic              core_grant, dbg_grant;
  logic [DATA_W-1:0] alu_new;
  logic              alu_wen, alu_err;

  // Exactly one of the two terms can win when both are valid, because
  // last_grant_q selects a single requester.
  assign core_grant = (state_q == ST_IDLE) & core.req_valid &
                      (~dbg.req_valid | (last_grant_q == OWN_DBG));
  assign dbg_grant  = (state_q == ST_IDLE) & dbg.req_valid &
                      (~core.req_valid | (last_grant_q == OWN_CORE));

  // The ALU sees the live file read data during READ so that its result
  // can be registered straight into the WRITE-cycle outputs.
  csr_rmw_alu #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_alu (
    .op       (op_q),
    .old      (csr_rd_data),
    .wdata    (wdata_q),
    .addr     (addr_q),
    .new_data (alu_new),
    .wen      (alu_wen),
    .err      (alu_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      last_grant_q      <= OWN_DBG;
      op_q              <= '0;
      addr_q            <= '0;
      wdata_q           <= '0;
      old_q             <= '0;
      wr_data_q         <= '0;
      we_q              <= 1'b0;
      err_q             <= 1'b0;
      core_resp_valid_q <= 1'b0;
      dbg_resp_valid_q  <= 1'b0;
      core_rdata_q      <= '0;
      dbg_rdata_q       <= '0;
      core_err_q        <= 1'b0;
      dbg_err_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (core_grant) begin
            last_grant_q <= OWN_CORE;
            op_q         <= core.op;
            addr_q       <= core.addr;
            wdata_q      <= core.wdata;
            state_q      <= ST_READ;
          end else if (dbg_grant) begin
            last_grant_q <= OWN_DBG;
            op_q         <= dbg.op;
            addr_q       <= dbg.addr;
            wdata_q      <= dbg.wdata;
            state_q      <= ST_READ;
          end
        end
        ST_READ: begin
          old_q     <= csr_rd_data;
          wr_data_q <= alu_new;
          we_q      <= alu_wen;
          err_q     <= alu_err;
          state_q   <= ST_WRITE;
        end
        ST_WRITE: begin
          we_q <= 1'b0;
          if (last_grant_q == OWN_CORE) begin
            core_resp_valid_q <= 1'b1;
            core_rdata_q      <= old_q;
            core_err_q        <= err_q;
          end else begin
            dbg_resp_valid_q  <= 1'b1;
            dbg_rdata_q       <= old_q;
            dbg_err_q         <= err_q;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          core_resp_valid_q <= 1'b0;
          dbg_resp_valid_q  <= 1'b0;
          state_q           <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core.req_ready  = core_grant;
  assign core.resp_valid = core_resp_valid_q;
  assign core.rdata      = core_rdata_q;
  assign core.resp_err   = core_err_q;

  assign dbg.req_ready   = dbg_grant;
  assign dbg.resp_valid  = dbg_resp_valid_q;
  assign dbg.rdata       = dbg_rdata_q;
  assign dbg.resp_err    = dbg_err_q;

  assign csr_addr    = addr_q;
  assign csr_we      = we_q;
  assign csr_wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_csr_access_arbiter                                      |
// | Description : Self-checking bench for csr_access_arbiter with a CSR file |
// |               model and a behavioural reference of the CSR op rules.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_csr_access_arbiter;
  import csr_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) core_bus ();
  csr_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg_bus ();

  logic [ADDR_W-1:0] csr_addr;
  logic [DATA_W-1:0] csr_rd_data;
  logic              csr_we;
  logic [DATA_W-1:0] csr_wr_data;

  csr_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .core        (core_bus),
    .dbg         (dbg_bus),
    .csr_addr    (csr_addr),
    .csr_rd_data (csr_rd_data),
    .csr_we      (csr_we),
    .csr_wr_data (csr_wr_data)
  );

  // CSR file: combinational read, write at posedge, plus a bench poke port.
  logic [DATA_W-1:0] file_mem [0:4095];
  logic              poke_en = 1'b0;
  logic [11:0]       poke_addr = '0;
  logic [31:0]       poke_data = '0;
  assign csr_rd_data = file_mem[csr_addr];
  always @(posedge clk) begin
    if (csr_we) file_mem[csr_addr] <= csr_wr_data;
    else if (poke_en) file_mem[poke_addr] <= poke_data;
  end

  // Reference state
  logic [31:0] ref_mem [0:4095];
  logic [31:0] exp_rd [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Event monitor, sampled on the falling edge
  typedef struct { int cyc; int who; } hs_t;
  typedef struct { int cyc; logic [11:0] addr; logic [31:0] data; } we_t;
  typedef struct { int cyc; logic [31:0] rdata; logic err; } rsp_t;
  hs_t  hs_log[$];
  we_t  we_log[$];
  rsp_t crsp_log[$];
  rsp_t drsp_log[$];
  int   cyc = 0;
  int   both_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (core_bus.req_valid && core_bus.req_ready) hs_log.push_back('{cyc, 0});
      if (dbg_bus.req_valid && dbg_bus.req_ready) hs_log.push_back('{cyc, 1});
      if (core_bus.req_ready && dbg_bus.req_ready) both_ready++;
      if (csr_we) we_log.push_back('{cyc, csr_addr, csr_wr_data});
      if (core_bus.resp_valid) crsp_log.push_back('{cyc, core_bus.rdata, core_bus.resp_err});
      if (dbg_bus.resp_valid) drsp_log.push_back('{cyc, dbg_bus.rdata, dbg_bus.resp_err});
    end
  end

  // Reference rules for one CSR op
  function automatic void ref_op(input logic [2:0] op, input logic [11:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] old,
                                 output bit wen, output logic [31:0] nv, output bit err);
    int  kind;
    bit  legal, writes;
    kind   = int'(op) % 4;
    legal  = (kind != 0);
    writes = (kind == 1) || (legal && wdata != 0);
    nv     = (kind == 1) ? wdata : (kind == 2) ? (old | wdata) : (old & ~wdata);
    err    = !legal || (writes && addr >= 12'hC00);
    wen    = writes && !err;
  endfunction

  task automatic drive(input int who, input logic v, input logic [2:0] op,
                       input logic [11:0] a, input logic [31:0] d);
    if (who == 0) begin
      core_bus.req_valid = v; core_bus.op = op; core_bus.addr = a; core_bus.wdata = d;
    end else begin
      dbg_bus.req_valid = v; dbg_bus.op = op; dbg_bus.addr = a; dbg_bus.wdata = d;
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Present a request until accepted (bounded), then withdraw and scramble it.
  task automatic issue(input int who, input logic [2:0] op, input logic [11:0] a,
                       input logic [31:0] d);
    bit got;
    got = 0;
    @(posedge clk); #1;
    drive(who, 1'b1, op, a, d);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (who == 0) ? core_bus.req_ready : dbg_bus.req_ready;
    end
    @(posedge clk); #1;
    drive(who, 1'b0, 3'($urandom), 12'($urandom), $urandom);
  endtask

  // Observations of one complete transaction
  int          o_hs_n, o_hs_who, o_hs_cyc, o_we_n, o_we_dly, o_rsp_n, o_rsp_dly, o_oth_n;
  logic [11:0] o_we_addr;
  logic [31:0] o_we_data, o_rdata, o_oth_rdata;
  logic        o_err;

  task automatic run_txn(input int who, input logic [2:0] op, input logic [11:0] a,
                         input logic [31:0] d);
    hs_log.delete(); we_log.delete(); crsp_log.delete(); drsp_log.delete();
    issue(who, op, a, d);
    repeat (5) @(posedge clk);
    #1;
    o_hs_n   = hs_log.size();
    o_hs_who = (o_hs_n > 0) ? hs_log[0].who : -1;
    o_hs_cyc = (o_hs_n > 0) ? hs_log[0].cyc : 0;
    o_we_n   = we_log.size();
    o_we_dly = (o_we_n > 0) ? we_log[0].cyc - o_hs_cyc : -1;
    o_we_addr = (o_we_n > 0) ? we_log[0].addr : '0;
    o_we_data = (o_we_n > 0) ? we_log[0].data : '0;
    if (who == 0) begin
      o_rsp_n = crsp_log.size();
      o_rsp_dly = (o_rsp_n > 0) ? crsp_log[0].cyc - o_hs_cyc : -1;
      o_rdata = (o_rsp_n > 0) ? crsp_log[0].rdata : '0;
      o_err   = (o_rsp_n > 0) ? crsp_log[0].err : 1'b0;
      o_oth_n = drsp_log.size();
      o_oth_rdata = dbg_bus.rdata;
    end else begin
      o_rsp_n = drsp_log.size();
      o_rsp_dly = (o_rsp_n > 0) ? drsp_log[0].cyc - o_hs_cyc : -1;
      o_rdata = (o_rsp_n > 0) ? drsp_log[0].rdata : '0;
      o_err   = (o_rsp_n > 0) ? drsp_log[0].err : 1'b0;
      o_oth_n = crsp_log.size();
      o_oth_rdata = core_bus.rdata;
    end
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 3'b000, '0, '0);
    drive(1, 1'b0, 3'b000, '0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({core_bus.req_ready, dbg_bus.req_ready, core_bus.resp_valid, dbg_bus.resp_valid,
         core_bus.resp_err, dbg_bus.resp_err, csr_we} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000", {core_bus.req_ready, dbg_bus.req_ready,
               core_bus.resp_valid, dbg_bus.resp_valid, core_bus.resp_err, dbg_bus.resp_err, csr_we});
    else n_pass++;
    n_checks++;
    if ({core_bus.rdata, dbg_bus.rdata, csr_addr, csr_wr_data} !== '0)
      $display("FAIL reset_data: got %h %h %h %h want all 0", core_bus.rdata, dbg_bus.rdata,
               csr_addr, csr_wr_data);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({core_bus.req_ready, dbg_bus.req_ready, csr_we, core_bus.resp_valid} !== 4'b0)
      $display("FAIL reset_release: got %b want 0000", {core_bus.req_ready, dbg_bus.req_ready,
               csr_we, core_bus.resp_valid});
    else n_pass++;
    exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  task automatic test_core_rw();
    poke(12'h340, 32'h0000_00FF);
    run_txn(0, CSRRW, 12'h340, 32'h0000_1234);
    n_checks++;
    if ({o_hs_n, o_we_n, o_we_dly, o_we_addr, o_we_data} !== {32'd1, 32'd1, 32'd2, 12'h340, 32'h1234})
      $display("FAIL core_rw_we: got n=%0d/%0d dly=%0d a=%h d=%h want 1/1 2 340 00001234",
               o_hs_n, o_we_n, o_we_dly, o_we_addr, o_we_data);
    else n_pass++;
    n_checks++;
    if ({o_rsp_n, o_rsp_dly, o_rdata, o_err, o_oth_n} !== {32'd1, 32'd3, 32'hFF, 1'b0, 32'd0})
      $display("FAIL core_rw_resp: got n=%0d dly=%0d rdata=%h err=%b dbg_n=%0d want 1 3 000000ff 0 0",
               o_rsp_n, o_rsp_dly, o_rdata, o_err, o_oth_n);
    else n_pass++;
    ref_mem[12'h340] = 32'h1234;
    exp_rd[0] = 32'hFF;
  endtask

  task automatic test_rs_zero();
    poke(12'h300, 32'hA5A5_0001);
    run_txn(0, CSRRS, 12'h300, 32'h0);
    n_checks++;
    if ({o_we_n, o_rsp_n, o_rsp_dly, o_rdata, o_err} !== {32'd0, 32'd1, 32'd3, 32'hA5A5_0001, 1'b0})
      $display("FAIL rs_zero: got we_n=%0d rsp=%0d dly=%0d rdata=%h err=%b want 0 1 3 a5a50001 0",
               o_we_n, o_rsp_n, o_rsp_dly, o_rdata, o_err);
    else n_pass++;
    n_checks++;
    if (file_mem[12'h300] !== 32'hA5A5_0001)
      $display("FAIL rs_zero_file: got %h want a5a50001", file_mem[12'h300]);
    else n_pass++;
    exp_rd[0] = 32'hA5A5_0001;
  endtask

  task automatic test_dbg_rc();
    poke(12'h7B0, 32'h0000_F0F0);
    run_txn(1, CSRRC, 12'h7B0, 32'h0000_00F0);
    n_checks++;
    if ({o_hs_who, o_we_n, o_we_dly, o_we_data} !== {32'd1, 32'd1, 32'd2, 32'h0000_F000})
      $display("FAIL dbg_rc_we: got who=%0d n=%0d dly=%0d d=%h want 1 1 2 0000f000",
               o_hs_who, o_we_n, o_we_dly, o_we_data);
    else n_pass++;
    n_checks++;
    if ({o_rsp_n, o_rsp_dly, o_rdata, o_err, o_oth_n} !== {32'd1, 32'd3, 32'h0000_F0F0, 1'b0, 32'd0})
      $display("FAIL dbg_rc_resp: got n=%0d dly=%0d rdata=%h err=%b core_n=%0d want 1 3 0000f0f0 0 0",
               o_rsp_n, o_rsp_dly, o_rdata, o_err, o_oth_n);
    else n_pass++;
    n_checks++;
    if (o_oth_rdata !== exp_rd[0])
      $display("FAIL dbg_rc_core_rdata: got %h want %h", o_oth_rdata, exp_rd[0]);
    else n_pass++;
    ref_mem[12'h7B0] = 32'h0000_F000;
    exp_rd[1] = 32'h0000_F0F0;
  endtask

  task automatic test_readonly();
    poke(12'hC00, 32'hDEAD_0001);
    run_txn(0, CSRRW, 12'hC00, 32'h5555_5555);
    n_checks++;
    if ({o_we_n, o_rsp_n, o_rdata, o_err} !== {32'd0, 32'd1, 32'hDEAD_0001, 1'b1})
      $display("FAIL ro_write: got we_n=%0d rsp=%0d rdata=%h err=%b want 0 1 dead0001 1",
               o_we_n, o_rsp_n, o_rdata, o_err);
    else n_pass++;
    run_txn(0, CSRRS, 12'hC00, 32'h0);
    n_checks++;
    if ({o_we_n, o_rsp_n, o_rdata, o_err} !== {32'd0, 32'd1, 32'hDEAD_0001, 1'b0})
      $display("FAIL ro_read: got we_n=%0d rsp=%0d rdata=%h err=%b want 0 1 dead0001 0",
               o_we_n, o_rsp_n, o_rdata, o_err);
    else n_pass++;
    exp_rd[0] = 32'hDEAD_0001;
  endtask

  task automatic test_round_robin();
    poke(12'h341, 32'h1111_0341);
    poke(12'h7B1, 32'h2222_07B1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b1, CSRRS, 12'h341, 32'h0);
    drive(1, 1'b1, CSRRS, 12'h7B1, 32'h0);
    hs_log.delete(); we_log.delete(); crsp_log.delete(); drsp_log.delete();
    both_ready = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 40 && hs_log.size() < 4; k++) @(posedge clk);
    #1;
    drive(0, 1'b0, 3'b000, '0, '0);
    drive(1, 1'b0, 3'b000, '0, '0);
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (hs_log.size() != 4)
      $display("FAIL rr_count: got %0d handshakes want 4", hs_log.size());
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (hs_log[i].who !== i % 2)
          $display("FAIL rr_order[%0d]: got %0d want %0d", i, hs_log[i].who, i % 2);
        else n_pass++;
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (hs_log[i].cyc - hs_log[i-1].cyc !== 4)
          $display("FAIL rr_spacing[%0d]: got %0d want 4", i, hs_log[i].cyc - hs_log[i-1].cyc);
        else n_pass++;
      end
      n_checks++;
      if (crsp_log.size() != 2 || drsp_log.size() != 2)
        $display("FAIL rr_resp_n: got core=%0d dbg=%0d want 2 2", crsp_log.size(), drsp_log.size());
      else if ({crsp_log[0].cyc - hs_log[0].cyc, crsp_log[1].cyc - hs_log[2].cyc,
                drsp_log[0].cyc - hs_log[1].cyc, drsp_log[1].cyc - hs_log[3].cyc,
                crsp_log[1].rdata, drsp_log[1].rdata} !==
               {32'd3, 32'd3, 32'd3, 32'd3, 32'h1111_0341, 32'h2222_07B1})
        $display("FAIL rr_resp: got dly %0d %0d %0d %0d rdata %h %h want 3 3 3 3 11110341 222207b1",
                 crsp_log[0].cyc - hs_log[0].cyc, crsp_log[1].cyc - hs_log[2].cyc,
                 drsp_log[0].cyc - hs_log[1].cyc, drsp_log[1].cyc - hs_log[3].cyc,
                 crsp_log[1].rdata, drsp_log[1].rdata);
      else n_pass++;
    end
    n_checks++;
    if (both_ready != 0) $display("FAIL rr_both_ready: got %0d cycles want 0", both_ready);
    else n_pass++;
    exp_rd[0] = 32'h1111_0341;
    exp_rd[1] = 32'h2222_07B1;
  endtask

  task automatic test_reset_mid();
    poke(12'h345, 32'h0BAD_F00D);
    hs_log.delete(); we_log.delete(); crsp_log.delete(); drsp_log.delete();
    issue(0, CSRRW, 12'h345, 32'h1111_2222);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (csr_we !== 1'b1) $display("FAIL rstmid_we_before: got %b want 1", csr_we);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (csr_we !== 1'b0) $display("FAIL rstmid_we_drop: got %b want 0", csr_we);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if ({crsp_log.size(), drsp_log.size(), file_mem[12'h345]} !== {32'd0, 32'd0, 32'h0BAD_F00D})
      $display("FAIL rstmid_lost: got core_n=%0d dbg_n=%0d file=%h want 0 0 0badf00d",
               crsp_log.size(), drsp_log.size(), file_mem[12'h345]);
    else n_pass++;
    run_txn(0, CSRRW, 12'h345, 32'h3333_4444);
    n_checks++;
    if ({o_hs_n, o_we_dly, o_we_data, o_rsp_dly, o_rdata, o_err} !==
        {32'd1, 32'd2, 32'h3333_4444, 32'd3, 32'h0BAD_F00D, 1'b0})
      $display("FAIL rstmid_retry: got hs=%0d wdly=%0d wd=%h rdly=%0d rdata=%h err=%b", o_hs_n,
               o_we_dly, o_we_data, o_rsp_dly, o_rdata, o_err);
    else n_pass++;
    ref_mem[12'h345] = 32'h3333_4444;
    exp_rd[0] = 32'h0BAD_F00D;
    exp_rd[1] = '0;
  endtask

  task automatic test_random();
    logic [11:0] pool [6];
    int          who, sel;
    logic [2:0]  op;
    logic [11:0] a;
    logic [31:0] d, exp_old, en;
    bit          ew, ee;
    pool[0] = 12'h340; pool[1] = 12'h341; pool[2] = 12'h300;
    pool[3] = 12'hC00; pool[4] = 12'hC01; pool[5] = 12'h7B0;
    for (int i = 0; i < 6; i++) poke(pool[i], $urandom);
    for (int t = 0; t < 60; t++) begin
      who = int'($urandom_range(0, 1));
      op  = 3'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 6));
      d   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if (sel == 6) begin
        a = 12'($urandom_range(0, 4095));
        poke(a, $urandom);
      end else a = pool[sel];
      exp_old = ref_mem[a];
      ref_op(op, a, d, exp_old, ew, en, ee);
      run_txn(who, op, a, d);
      n_checks++;
      if ({o_hs_n, o_hs_who} !== {32'd1, who})
        $display("FAIL rnd%0d_hs: got n=%0d who=%0d want 1 %0d", t, o_hs_n, o_hs_who, who);
      else n_pass++;
      n_checks++;
      if (ew ? ({o_we_n, o_we_dly, o_we_addr, o_we_data} !== {32'd1, 32'd2, a, en})
             : (o_we_n !== 0))
        $display("FAIL rnd%0d_we: got n=%0d dly=%0d a=%h d=%h want wen=%0d a=%h d=%h", t,
                 o_we_n, o_we_dly, o_we_addr, o_we_data, ew, a, en);
      else n_pass++;
      n_checks++;
      if ({o_rsp_n, o_rsp_dly, o_rdata, o_err} !== {32'd1, 32'd3, exp_old, ee})
        $display("FAIL rnd%0d_resp: got n=%0d dly=%0d rdata=%h err=%b want 1 3 %h %b", t,
                 o_rsp_n, o_rsp_dly, o_rdata, o_err, exp_old, ee);
      else n_pass++;
      n_checks++;
      if ({o_oth_n, o_oth_rdata} !== {32'd0, exp_rd[1-who]})
        $display("FAIL rnd%0d_other: got n=%0d rdata=%h want 0 %h", t, o_oth_n, o_oth_rdata,
                 exp_rd[1-who]);
      else n_pass++;
      if (ew) ref_mem[a] = en;
      exp_rd[who] = exp_old;
      n_checks++;
      if (file_mem[a] !== ref_mem[a])
        $display("FAIL rnd%0d_file: got %h want %h", t, file_mem[a], ref_mem[a]);
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d checks", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_core_rw();
    test_rs_zero();
    test_dbg_rc();
    test_readonly();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
